tx_req_inflight_limiter: RTL and testbench

- Per-port admission controller placed between the per-interface transmit schedulers and the transmit request mux.
- Tracks, for each port, how many transmit requests are in flight: accepted downstream but not yet retired by status feedback.
- Stalls a port's request stream while its in-flight count is at or above a programmable limit. This bounds per-port occupancy of the shared transmit engine and stops one port from monopolising it.

---
 rtl/tx_req_inflight_limiter_pkg.sv | 23 ++
 rtl/tx_req_inflight_limiter_if.sv | 24 ++
 rtl/tx_inflight_counter.sv | 67 ++++++
 rtl/tx_req_inflight_limiter.sv | 79 +++++++
 tb/tb_tx_req_inflight_limiter.sv | 344 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tx_req_inflight_limiter_pkg.sv
// Shared definitions for the transmit request in-flight limiter.
// - CNT_WIDTH_DEFAULT: default width of each in-flight counter and limit
//   field. Driver and CSR code use the same value.
// - Retire-event encoding: one bit per retire source in retire_vec_t.
// - retire_count(): the number of retire events set in a retire_vec_t.
package tx_req_inflight_limiter_pkg;

    localparam int CNT_WIDTH_DEFAULT = 6;

    // Bit positions of the retire sources inside a retire vector.
    localparam int RETIRE_DEQ   = 0;  // dequeue reported empty or error; nothing was sent
    localparam int RETIRE_START = 1;  // transmit start failed
    localparam int RETIRE_FIN   = 2;  // transmit finished
    localparam int RETIRE_NUM   = 3;

    typedef logic [RETIRE_NUM-1:0] retire_vec_t;

    // Up to three retire events can land in the same cycle.
    function automatic logic [1:0] retire_count(input retire_vec_t ev);
        return {1'b0, ev[RETIRE_DEQ]} + {1'b0, ev[RETIRE_START]} + {1'b0, ev[RETIRE_FIN]};
    endfunction

endpackage

// File: rtl/tx_req_inflight_limiter_if.sv
// Transmit request stream bundle, packed for PORTS ports.
// - queue, tag, dest: per-port request fields, concatenated with port 0 in
//   the least significant slice.
// - valid, ready: per-port handshake.
// Modports:
// - master: drives the request and samples ready.
// - slave: receives the request and drives ready.
interface tx_req_inflight_limiter_if
    import tx_req_inflight_limiter_pkg::*;
#(
    parameter int PORTS             = 2,
    parameter int QUEUE_INDEX_WIDTH = 4,
    parameter int REQ_TAG_WIDTH     = 8,
    parameter int DEST_WIDTH        = 8
);
    logic [PORTS*QUEUE_INDEX_WIDTH-1:0] queue;
    logic [PORTS*REQ_TAG_WIDTH-1:0]     tag;
    logic [PORTS*DEST_WIDTH-1:0]        dest;
    logic [PORTS-1:0]                   valid;
    logic [PORTS-1:0]                   ready;

    modport master (output queue, tag, dest, valid, input ready);
    modport slave  (input queue, tag, dest, valid, output ready);
endinterface

// File: rtl/tx_inflight_counter.sv
// In-flight counter and limit compare for a single port.
// Ports:
// - clk, rst: clock and synchronous active-high reset.
// - cfg_limit, cfg_enable: admission limit and enable for this port.
// - inc: a request was accepted downstream this cycle.
// - retire: retire events seen this cycle (see the package encoding).
// - admit: combinational; the port may accept a request this cycle.
// - cnt: registered in-flight count.
// - idle: registered; high while cnt is zero.
// - underflow: sticky; a retire arrived that would take the count below zero.
module tx_inflight_counter
    import tx_req_inflight_limiter_pkg::*;
#(
    parameter int CNT_WIDTH = CNT_WIDTH_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [CNT_WIDTH-1:0] cfg_limit,
    input  logic                 cfg_enable,
    input  logic                 inc,
    input  retire_vec_t          retire,
    output logic                 admit,
    output logic [CNT_WIDTH-1:0] cnt,
    output logic                 idle,
    output logic                 underflow
);
    // Two extra bits: one for the +1 carry, one for the sign.
    localparam int SW = CNT_WIDTH + 2;

    logic [CNT_WIDTH-1:0] cnt_reg, cnt_next;
    logic                 idle_reg;
    logic                 underflow_reg, underflow_next;
    logic [SW-1:0]        sum;

    // Compare against the registered count only. This keeps ready free of
    // any path from this cycle's valid.
    assign admit = cfg_enable && (cnt_reg < cfg_limit);

    always_comb begin
        sum            = {2'b00, cnt_reg} + SW'(inc) - SW'(retire_count(retire));
        cnt_next       = sum[CNT_WIDTH-1:0];
        underflow_next = underflow_reg;
        if (sum[SW-1]) begin
            // More retires than in-flight requests: floor at zero and flag it.
            cnt_next       = '0;
            underflow_next = 1'b1;
        end else if (sum[SW-2]) begin
            cnt_next = '1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg       <= '0;
            idle_reg      <= 1'b1;
            underflow_reg <= 1'b0;
        end else begin
            cnt_reg       <= cnt_next;
            idle_reg      <= (cnt_next == '0);
            underflow_reg <= underflow_next;
        end
    end

    assign cnt       = cnt_reg;
    assign idle      = idle_reg;
    assign underflow = underflow_reg;
endmodule

// File: rtl/tx_req_inflight_limiter.sv
// Per-port admission control between the transmit schedulers and the
// transmit request mux. A port is stalled while its count of in-flight
// requests is at or above cfg_limit. A request is in flight from the time
// it is accepted downstream until status feedback retires it. The request
// path has no latency and no buffering.
// Ports:
// - clk, rst: clock and synchronous active-high reset.
// - s_axis_req: slave request bundle from the schedulers.
// - m_axis_req: master request bundle to the mux.
// - s_axis_status_*: per-port dequeue, start and finish status, used to
//   retire requests.
// - cfg_limit, cfg_enable: per-port limit (0 blocks the port) and enable.
// - stat_inflight, stat_idle, stat_underflow: per-port counter state.
module tx_req_inflight_limiter
    import tx_req_inflight_limiter_pkg::*;
#(
    parameter int PORTS             = 2,
    parameter int QUEUE_INDEX_WIDTH = 4,
    parameter int REQ_TAG_WIDTH     = 8,
    parameter int DEST_WIDTH        = 8,
    parameter int CNT_WIDTH         = CNT_WIDTH_DEFAULT
) (
    input  logic                       clk,
    input  logic                       rst,
    tx_req_inflight_limiter_if.slave   s_axis_req,
    tx_req_inflight_limiter_if.master  m_axis_req,
    input  logic [PORTS-1:0]           s_axis_status_dequeue_empty,
    input  logic [PORTS-1:0]           s_axis_status_dequeue_error,
    input  logic [PORTS-1:0]           s_axis_status_dequeue_valid,
    input  logic [PORTS-1:0]           s_axis_status_start_error,
    input  logic [PORTS-1:0]           s_axis_status_start_valid,
    input  logic [PORTS-1:0]           s_axis_status_finish_valid,
    input  logic [PORTS*CNT_WIDTH-1:0] cfg_limit,
    input  logic [PORTS-1:0]           cfg_enable,
    output logic [PORTS*CNT_WIDTH-1:0] stat_inflight,
    output logic [PORTS-1:0]           stat_idle,
    output logic [PORTS-1:0]           stat_underflow
);
    logic [PORTS-1:0] admit;

    // Request fields pass through unchanged; only the handshake is gated.
    assign m_axis_req.queue = s_axis_req.queue;
    assign m_axis_req.tag   = s_axis_req.tag;
    assign m_axis_req.dest  = s_axis_req.dest;

    genvar gi;
    generate
        for (gi = 0; gi < PORTS; gi++) begin : g_port
            retire_vec_t retire_ev;

            assign m_axis_req.valid[gi] = s_axis_req.valid[gi] && admit[gi];
            assign s_axis_req.ready[gi] = m_axis_req.ready[gi] && admit[gi];

            // A dequeue with neither flag set, or a start without error,
            // leaves the request in flight.
            assign retire_ev[RETIRE_DEQ]   = s_axis_status_dequeue_valid[gi] &&
                                             (s_axis_status_dequeue_empty[gi] ||
                                              s_axis_status_dequeue_error[gi]);
            assign retire_ev[RETIRE_START] = s_axis_status_start_valid[gi] &&
                                             s_axis_status_start_error[gi];
            assign retire_ev[RETIRE_FIN]   = s_axis_status_finish_valid[gi];

            tx_inflight_counter #(
                .CNT_WIDTH (CNT_WIDTH)
            ) u_cnt (
                .clk        (clk),
                .rst        (rst),
                .cfg_limit  (cfg_limit[gi*CNT_WIDTH +: CNT_WIDTH]),
                .cfg_enable (cfg_enable[gi]),
                .inc        (m_axis_req.valid[gi] && m_axis_req.ready[gi]),
                .retire     (retire_ev),
                .admit      (admit[gi]),
                .cnt        (stat_inflight[gi*CNT_WIDTH +: CNT_WIDTH]),
                .idle       (stat_idle[gi]),
                .underflow  (stat_underflow[gi])
            );
        end
    endgenerate
endmodule

// File: tb/tb_tx_req_inflight_limiter.sv
module tb_tx_req_inflight_limiter;
    localparam int CW = 6;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    tx_req_inflight_limiter_if #(.PORTS(2), .QUEUE_INDEX_WIDTH(4), .REQ_TAG_WIDTH(8), .DEST_WIDTH(8)) s_if ();
    tx_req_inflight_limiter_if #(.PORTS(2), .QUEUE_INDEX_WIDTH(4), .REQ_TAG_WIDTH(8), .DEST_WIDTH(8)) m_if ();

    logic [1:0]    deq_empty, deq_error, deq_valid, start_error, start_valid, finish_valid;
    logic [1:0]    cfg_enable, stat_idle, stat_underflow;
    logic [2*CW-1:0] cfg_limit, stat_inflight;

    int n_cmp = 0;
    int n_err = 0;

    tx_req_inflight_limiter #(
        .PORTS(2), .QUEUE_INDEX_WIDTH(4), .REQ_TAG_WIDTH(8), .DEST_WIDTH(8), .CNT_WIDTH(CW)
    ) dut (
        .clk                         (clk),
        .rst                         (rst),
        .s_axis_req                  (s_if),
        .m_axis_req                  (m_if),
        .s_axis_status_dequeue_empty (deq_empty),
        .s_axis_status_dequeue_error (deq_error),
        .s_axis_status_dequeue_valid (deq_valid),
        .s_axis_status_start_error   (start_error),
        .s_axis_status_start_valid   (start_valid),
        .s_axis_status_finish_valid  (finish_valid),
        .cfg_limit                   (cfg_limit),
        .cfg_enable                  (cfg_enable),
        .stat_inflight               (stat_inflight),
        .stat_idle                   (stat_idle),
        .stat_underflow              (stat_underflow)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs;
        s_if.queue   = 8'h00;
        s_if.tag     = 16'h0000;
        s_if.dest    = 16'h0000;
        s_if.valid   = 2'b00;
        m_if.ready   = 2'b11;
        deq_empty    = 2'b00;
        deq_error    = 2'b00;
        deq_valid    = 2'b00;
        start_error  = 2'b00;
        start_valid  = 2'b00;
        finish_valid = 2'b00;
        cfg_enable   = 2'b11;
        cfg_limit    = {6'd4, 6'd4};
    endtask

    task automatic do_reset;
        clear_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset;
        do_reset();
        cfg_enable = 2'b00;
        cfg_limit  = '0;
        #1;
        n_cmp++;
        if ({stat_inflight, stat_idle, stat_underflow} !== {12'd0, 2'b11, 2'b00}) begin
            n_err++;
            $display("FAIL reset_stat: got infl=%h idle=%b uf=%b want infl=000 idle=11 uf=00",
                     stat_inflight, stat_idle, stat_underflow);
        end
        n_cmp++;
        if ({m_if.valid, s_if.ready} !== 4'b0000) begin
            n_err++;
            $display("FAIL reset_hs: got m_valid=%b s_ready=%b want 00/00", m_if.valid, s_if.ready);
        end
        // Ready must not depend on valid: admitted ports show ready with valid low.
        cfg_enable = 2'b11;
        cfg_limit  = {6'd1, 6'd1};
        #1;
        n_cmp++;
        if ({m_if.valid, s_if.ready} !== 4'b0011) begin
            n_err++;
            $display("FAIL ready_no_valid: got m_valid=%b s_ready=%b want 00/11", m_if.valid, s_if.ready);
        end
        $display("test_reset done");
    endtask

    task automatic test_limit;
        do_reset();
        cfg_limit  = {6'd4, 6'd2};
        s_if.valid = 2'b01;
        s_if.queue = 8'h03;
        #1;
        n_cmp++;
        if ({m_if.valid, s_if.ready} !== 4'b0111) begin
            n_err++;
            $display("FAIL lim_req1: got m_valid=%b s_ready=%b want 01/11", m_if.valid, s_if.ready);
        end
        tick();
        n_cmp++;
        if ({m_if.valid, s_if.ready} !== 4'b0111) begin
            n_err++;
            $display("FAIL lim_req2: got m_valid=%b s_ready=%b want 01/11", m_if.valid, s_if.ready);
        end
        tick();
        n_cmp++;
        if ({m_if.valid, s_if.ready, stat_inflight[CW-1:0]} !== {4'b0010, 6'd2}) begin
            n_err++;
            $display("FAIL lim_block: got m_valid=%b s_ready=%b cnt0=%0d want 00/10 cnt0=2",
                     m_if.valid, s_if.ready, stat_inflight[CW-1:0]);
        end
        tick();
        finish_valid = 2'b01;
        tick();
        finish_valid = 2'b00;
        n_cmp++;
        if ({m_if.valid[0], stat_inflight[CW-1:0]} !== {1'b1, 6'd1}) begin
            n_err++;
            $display("FAIL lim_resume: got m_valid0=%b cnt0=%0d want 1 cnt0=1",
                     m_if.valid[0], stat_inflight[CW-1:0]);
        end
        tick();
        n_cmp++;
        if ({m_if.valid, stat_inflight} !== {2'b00, 6'd0, 6'd2}) begin
            n_err++;
            $display("FAIL lim_reblock: got m_valid=%b infl=%h want 00 infl=002", m_if.valid, stat_inflight);
        end
        s_if.valid = 2'b00;
        $display("test_limit done");
    endtask

    task automatic test_coincident_retire;
        do_reset();
        cfg_limit  = {6'd4, 6'd3};
        s_if.valid = 2'b01;
        tick();
        tick();
        // cnt0=2: increment plus three retires in one cycle
        deq_valid = 2'b01; deq_empty = 2'b01;
        start_valid = 2'b01; start_error = 2'b01;
        finish_valid = 2'b01;
        #1;
        n_cmp++;
        if (m_if.valid[0] !== 1'b1) begin
            n_err++;
            $display("FAIL coin_admit: got m_valid0=%b want 1", m_if.valid[0]);
        end
        tick();
        clear_inputs();
        cfg_limit = {6'd4, 6'd3};
        n_cmp++;
        if ({stat_inflight, stat_idle, stat_underflow} !== {12'd0, 2'b11, 2'b00}) begin
            n_err++;
            $display("FAIL coin_net: got infl=%h idle=%b uf=%b want 000/11/00",
                     stat_inflight, stat_idle, stat_underflow);
        end
        s_if.valid = 2'b01;
        tick();
        s_if.valid = 2'b00;
        // Non-retiring status forms
        deq_valid = 2'b01;
        start_valid = 2'b01;
        tick();
        deq_valid = 2'b00;
        start_valid = 2'b00;
        n_cmp++;
        if ({stat_inflight[CW-1:0], stat_idle} !== {6'd1, 2'b10}) begin
            n_err++;
            $display("FAIL coin_noretire: got cnt0=%0d idle=%b want 1/10", stat_inflight[CW-1:0], stat_idle);
        end
        deq_valid = 2'b01;
        deq_error = 2'b01;
        tick();
        deq_valid = 2'b00;
        deq_error = 2'b00;
        n_cmp++;
        if ({stat_inflight[CW-1:0], stat_underflow} !== {6'd0, 2'b00}) begin
            n_err++;
            $display("FAIL coin_deqerr: got cnt0=%0d uf=%b want 0/00", stat_inflight[CW-1:0], stat_underflow);
        end
        $display("test_coincident_retire done");
    endtask

    task automatic test_underflow;
        do_reset();
        finish_valid = 2'b01;
        tick();
        finish_valid = 2'b00;
        n_cmp++;
        if ({stat_inflight, stat_underflow, stat_idle} !== {12'd0, 2'b01, 2'b11}) begin
            n_err++;
            $display("FAIL uf_set: got infl=%h uf=%b idle=%b want 000/01/11", stat_inflight, stat_underflow, stat_idle);
        end
        s_if.valid = 2'b01;
        tick();
        s_if.valid = 2'b00;
        tick();
        n_cmp++;
        if ({stat_inflight[CW-1:0], stat_underflow} !== {6'd1, 2'b01}) begin
            n_err++;
            $display("FAIL uf_sticky: got cnt0=%0d uf=%b want 1/01", stat_inflight[CW-1:0], stat_underflow);
        end
        $display("test_underflow done");
    endtask

    task automatic test_limit_lower;
        do_reset();
        s_if.valid = 2'b01;
        tick();
        s_if.valid = 2'b11;
        tick();
        s_if.valid = 2'b01;
        tick();
        s_if.valid = 2'b00;
        n_cmp++;
        if (stat_inflight !== {6'd1, 6'd3}) begin
            n_err++;
            $display("FAIL low_counts: got infl=%h want cnt1=1 cnt0=3", stat_inflight);
        end
        cfg_limit  = {6'd4, 6'd1};
        s_if.valid = 2'b11;
        #1;
        n_cmp++;
        if ({m_if.valid, s_if.ready} !== 4'b1010) begin
            n_err++;
            $display("FAIL low_block: got m_valid=%b s_ready=%b want 10/10", m_if.valid, s_if.ready);
        end
        s_if.valid   = 2'b01;
        finish_valid = 2'b01;
        tick();
        tick();
        n_cmp++;
        if ({m_if.valid, stat_inflight[CW-1:0]} !== {2'b00, 6'd1}) begin
            n_err++;
            $display("FAIL low_drain: got m_valid=%b cnt0=%0d want 00 cnt0=1", m_if.valid, stat_inflight[CW-1:0]);
        end
        tick();
        finish_valid = 2'b00;
        #1;
        n_cmp++;
        if ({m_if.valid, stat_inflight} !== {2'b01, 6'd1, 6'd0}) begin
            n_err++;
            $display("FAIL low_resume: got m_valid=%b infl=%h want 01 cnt1=1 cnt0=0", m_if.valid, stat_inflight);
        end
        s_if.valid = 2'b00;
        $display("test_limit_lower done");
    endtask

    task automatic test_enable;
        do_reset();
        cfg_enable = 2'b01;
        s_if.valid = 2'b10;
        s_if.queue = {4'd5, 4'd0};
        s_if.tag   = {8'h3A, 8'h00};
        s_if.dest  = {8'h11, 8'h00};
        #1;
        n_cmp++;
        if ({m_if.valid, s_if.ready} !== 4'b0001) begin
            n_err++;
            $display("FAIL en_block: got m_valid=%b s_ready=%b want 00/01", m_if.valid, s_if.ready);
        end
        tick();
        n_cmp++;
        if (stat_inflight !== 12'd0) begin
            n_err++;
            $display("FAIL en_nocount: got infl=%h want 000", stat_inflight);
        end
        cfg_enable = 2'b11;
        #1;
        n_cmp++;
        if ({m_if.valid, s_if.ready, m_if.queue, m_if.tag, m_if.dest} !== {2'b10, 2'b11, 8'h50, 16'h3A00, 16'h1100}) begin
            n_err++;
            $display("FAIL en_pass: got m_valid=%b s_ready=%b q=%h tag=%h dest=%h want 10/11 q=50 tag=3a00 dest=1100",
                     m_if.valid, s_if.ready, m_if.queue, m_if.tag, m_if.dest);
        end
        tick();
        s_if.valid = 2'b00;
        n_cmp++;
        if (stat_inflight !== {6'd1, 6'd0}) begin
            n_err++;
            $display("FAIL en_count: got infl=%h want cnt1=1 cnt0=0", stat_inflight);
        end
        // A zero limit blocks the port even when enabled.
        cfg_limit  = {6'd0, 6'd4};
        s_if.valid = 2'b10;
        #1;
        n_cmp++;
        if ({m_if.valid, s_if.ready} !== 4'b0001) begin
            n_err++;
            $display("FAIL en_limit0: got m_valid=%b s_ready=%b want 00/01", m_if.valid, s_if.ready);
        end
        s_if.valid = 2'b00;
        $display("test_enable done");
    endtask

    task automatic test_rst_mid;
        do_reset();
        cfg_limit    = {6'd8, 6'd8};
        s_if.valid   = 2'b01;
        finish_valid = 2'b10;
        tick();
        finish_valid = 2'b00;
        tick();
        tick();
        tick();
        n_cmp++;
        if ({stat_inflight, stat_underflow} !== {6'd0, 6'd4, 2'b10}) begin
            n_err++;
            $display("FAIL mid_pre: got infl=%h uf=%b want cnt0=4 uf=10", stat_inflight, stat_underflow);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_cmp++;
        if ({stat_inflight, stat_idle, stat_underflow, m_if.valid} !== {12'd0, 2'b11, 2'b00, 2'b01}) begin
            n_err++;
            $display("FAIL mid_rst: got infl=%h idle=%b uf=%b m_valid=%b want 000/11/00/01",
                     stat_inflight, stat_idle, stat_underflow, m_if.valid);
        end
        s_if.valid = 2'b00;
        $display("test_rst_mid done");
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        test_reset();
        test_limit();
        test_coincident_retire();
        test_underflow();
        test_limit_lower();
        test_enable();
        test_rst_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
